// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec -- single-cycle ALU execute stage with a one-entry response buffer.
//
// A request is accepted when req_valid & req_ready. The result, per-op flags
// and error bit are registered on the accepting edge and held in the response
// buffer until the consumer takes them (rsp_ready). A new request can be
// accepted on the same edge the held response is taken, so back-to-back
// traffic flows without bubbles.
//
// Parameters:
//   W            operand/result width (default 20)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid    request present
//   req_ready    request accepted when high together with req_valid
//   req_op       opcode (see op_e)
//   req_a/req_b  operands A and B
//   rsp_valid    response held in the output buffer
//   rsp_ready    consumer takes the response
//   rsp_result   result
//   rsp_flags    {carry, sign, zero} for this op
//   rsp_err      illegal opcode
//   sreg         status register {carry, sign, zero}, updated on legal ops
//
// Configuration:
//   ALU_EXEC_CARRY_CHAIN_EN  when defined, ADC (0xB) and SBB (0xD) use the
//                            carry held in sreg; when undefined both opcodes
//                            are treated as illegal.
// ---------------------------------------------------------------------------
module alu_exec #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [3:0]   req_op,
  input  logic [W-1:0] req_a,
  input  logic [W-1:0] req_b,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [W-1:0] rsp_result,
  output logic [2:0]   rsp_flags,
  output logic         rsp_err,
  output logic [2:0]   sreg
);

  typedef enum logic [3:0] {
    OP_NOT = 4'h0,
    OP_AND = 4'h1,
    OP_OR  = 4'h2,
    OP_XOR = 4'h3,
    OP_SHR = 4'h4,
    OP_SHL = 4'h5,
    OP_ROR = 4'h6,
    OP_ROL = 4'h7,
    OP_INC = 4'h8,
    OP_DEC = 4'h9,
    OP_ADD = 4'hA,
    OP_ADC = 4'hB,
    OP_SUB = 4'hC,
    OP_SBB = 4'hD,
    OP_CMP = 4'hE,
    OP_ILL = 4'hF
  } op_e;

  // Flag bit positions inside rsp_flags / sreg.
  localparam int FLAG_C = 2;
  localparam int FLAG_S = 1;
  localparam int FLAG_Z = 0;

  localparam logic [W:0] ONE_EXT = (W+1)'(1);

  // -------------------------------------------------------------------------
  // Handshake: the buffer can take a new response when it is empty or when
  // the held response leaves on this same edge.
  // -------------------------------------------------------------------------
  logic accept;

  assign req_ready = ~rsp_valid | rsp_ready;
  assign accept    = req_valid & req_ready;

  // -------------------------------------------------------------------------
  // Datapath. Arithmetic is done one bit wider than the operands so that
  // bit W is the carry-out for additions and the borrow for subtractions
  // (a negative two's-complement difference sets the top bit).
  // -------------------------------------------------------------------------
  logic [W:0]   ext_a;
  logic [W:0]   ext_b;
  logic [W:0]   wide;
  logic [W-1:0] nxt_result;
  logic [W-1:0] flag_src;
  logic         nxt_carry;
  logic         nxt_err;
  logic [2:0]   nxt_flags;

  assign ext_a = {1'b0, req_a};
  assign ext_b = {1'b0, req_b};

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    wide       = '0;
    nxt_result = '0;
    nxt_carry  = 1'b0;
    nxt_err    = 1'b0;
    flag_src   = '0;

    unique case (op_e'(req_op))
      OP_NOT: nxt_result = ~req_a;
      OP_AND: nxt_result = req_a & req_b;
      OP_OR:  nxt_result = req_a | req_b;
      OP_XOR: nxt_result = req_a ^ req_b;

      // Shifts fill with zero and report the bit pushed out.
      OP_SHR: begin
        nxt_result = req_a >> 1;
        nxt_carry  = req_a[0];
      end
      OP_SHL: begin
        nxt_result = req_a << 1;
        nxt_carry  = req_a[W-1];
      end

      // Rotates report the bit that wrapped around.
      OP_ROR: begin
        nxt_result = {req_a[0], req_a[W-1:1]};
        nxt_carry  = req_a[0];
      end
      OP_ROL: begin
        nxt_result = {req_a[W-2:0], req_a[W-1]};
        nxt_carry  = req_a[W-1];
      end

      OP_INC: begin
        wide       = ext_a + ONE_EXT;
        nxt_result = wide[W-1:0];
        nxt_carry  = wide[W];
      end
      OP_DEC: begin
        wide       = ext_a - ONE_EXT;
        nxt_result = wide[W-1:0];
        nxt_carry  = wide[W];
      end
      OP_ADD: begin
        wide       = ext_a + ext_b;
        nxt_result = wide[W-1:0];
        nxt_carry  = wide[W];
      end
      OP_SUB: begin
        wide       = ext_a - ext_b;
        nxt_result = wide[W-1:0];
        nxt_carry  = wide[W];
      end

`ifdef ALU_EXEC_CARRY_CHAIN_EN
      // Chained ops use the carry registered before this edge, so a chain
      // issued back-to-back sees the previous op's carry/borrow.
      OP_ADC: begin
        wide       = ext_a + ext_b + {{W{1'b0}}, sreg[FLAG_C]};
        nxt_result = wide[W-1:0];
        nxt_carry  = wide[W];
      end
      OP_SBB: begin
        wide       = ext_a - ext_b - {{W{1'b0}}, sreg[FLAG_C]};
        nxt_result = wide[W-1:0];
        nxt_carry  = wide[W];
      end
`else
      OP_ADC: nxt_err = 1'b1;
      OP_SBB: nxt_err = 1'b1;
`endif

      // CMP returns A unchanged; the flags describe a - b.
      OP_CMP: begin
        wide       = ext_a - ext_b;
        nxt_result = req_a;
        nxt_carry  = wide[W];
      end

      OP_ILL:  nxt_err = 1'b1;
      default: nxt_err = 1'b1;
    endcase

    flag_src = (op_e'(req_op) == OP_CMP) ? wide[W-1:0] : nxt_result;

    // Illegal ops report a clean all-zero result and no flags.
    if (nxt_err) begin
      nxt_result = '0;
      nxt_carry  = 1'b0;
      flag_src   = '0;
    end
  end

  always_comb begin
    nxt_flags         = '0;
    nxt_flags[FLAG_C] = nxt_carry;
    nxt_flags[FLAG_S] = flag_src[W-1] & ~nxt_err;
    nxt_flags[FLAG_Z] = (flag_src == '0) & ~nxt_err;
  end

  // -------------------------------------------------------------------------
  // Response buffer and status register. Reset clears everything at once,
  // discarding any held response.
  // -------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values (ADC/SBB read sreg on the same edge it loads).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_flags  <= '0;
      rsp_err    <= 1'b0;
      sreg       <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_result <= nxt_result;
      rsp_flags  <= nxt_flags;
      rsp_err    <= nxt_err;
      if (!nxt_err) begin
        sreg <= nxt_flags;
      end
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// ---------------------------------------------------------------------------
// tb_alu_exec -- self-checking bench for alu_exec.
//
// Directed steps cover reset, the carry chain, output-buffer back-pressure,
// shift/rotate/compare corners, illegal opcodes, wrap-around and an
// asynchronous reset while a response is held; a randomized phase follows.
// Expected values come from a transaction-level reference model that works
// on plain integer arithmetic.
// ---------------------------------------------------------------------------
module tb_alu_exec;

  localparam int     W    = 20;
  localparam longint MASK = (longint'(1) << W) - 1;
`ifdef ALU_EXEC_CARRY_CHAIN_EN
  localparam bit CHAIN = 1'b1;
`else
  localparam bit CHAIN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic         req_valid;
  logic         req_ready;
  logic [3:0]   req_op;
  logic [W-1:0] req_a;
  logic [W-1:0] req_b;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic [2:0]   rsp_flags;
  logic         rsp_err;
  logic [2:0]   sreg;

  alu_exec #(.W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .rsp_err    (rsp_err),
    .sreg       (sreg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state: what the response buffer and sreg should hold.
  bit         m_valid;
  longint     m_res;
  logic [2:0] m_flags;
  bit         m_err;
  logic [2:0] m_sreg;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural ALU: integer arithmetic, carry/borrow = result out of range.
  task automatic ref_op(input logic [3:0] op, input longint a, input longint b,
                        input bit cin, output longint r, output logic [2:0] f,
                        output bit e);
    longint s;
    longint fv;
    bit     c;
    bool_arith: begin end
    s = 0;
    c = 1'b0;
    e = 1'b0;
    r = 0;
    case (op)
      4'h0: r = ~a & MASK;
      4'h1: r = a & b;
      4'h2: r = a | b;
      4'h3: r = a ^ b;
      4'h4: begin r = a >> 1;                          c = a[0];   end
      4'h5: begin r = (a << 1) & MASK;                 c = a[W-1]; end
      4'h6: begin r = (a >> 1) | ((a & 1) << (W-1));  c = a[0];   end
      4'h7: begin r = ((a << 1) & MASK) | (a >> (W-1)); c = a[W-1]; end
      4'h8: s = a + 1;
      4'h9: s = a - 1;
      4'hA: s = a + b;
      4'hB: if (CHAIN) s = a + b + longint'(cin); else e = 1'b1;
      4'hC: s = a - b;
      4'hD: if (CHAIN) s = a - b - longint'(cin); else e = 1'b1;
      4'hE: s = a - b;
      default: e = 1'b1;
    endcase
    if (op >= 4'h8 && !e) begin
      c = (s < 0) || (s > MASK);
      r = s & MASK;
    end
    fv = (op == 4'hE) ? (s & MASK) : r;
    if (op == 4'hE) r = a;
    if (e) begin
      r = 0;
      f = 3'b000;
    end else begin
      f = {c, fv[W-1], (fv == 0)};
    end
  endtask

  // One clock cycle of stimulus, entered just after a falling edge.
  task automatic cycle(input bit v, input logic [3:0] op, input longint a,
                       input longint b, input bit rr);
    longint     r;
    logic [2:0] f;
    bit         e;
    bit         acc;
    req_valid = v;
    req_op    = op;
    req_a     = a[W-1:0];
    req_b     = b[W-1:0];
    rsp_ready = rr;
    #1;
    check("req_ready", 32'(req_ready), 32'(!m_valid || rr));
    acc = v && (!m_valid || rr);
    if (acc) ref_op(op, a, b, m_sreg[2], r, f, e);
    @(posedge clk);
    if (acc) begin
      m_valid = 1'b1;
      m_res   = r;
      m_flags = f;
      m_err   = e;
      if (!e) m_sreg = f;
    end else if (rr) begin
      m_valid = 1'b0;
    end
    #1;
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      check("rsp_result", 32'(rsp_result), 32'(m_res));
      check("rsp_flags", 32'(rsp_flags), 32'(m_flags));
      check("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    check("sreg", 32'(sreg), 32'(m_sreg));
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_res   = 0;
    m_flags = 3'b000;
    m_err   = 1'b0;
    m_sreg  = 3'b000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint a;
    longint b;

    // --- Reset state -------------------------------------------------------
    model_reset();
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 4'h0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    #12;
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_result", 32'(rsp_result), 32'd0);
    check("reset_rsp_flags", 32'(rsp_flags), 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_sreg", 32'(sreg), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // --- ADD wrap to zero --------------------------------------------------
    cycle(1'b1, 4'hA, 'hFFFFF, 'h00001, 1'b1);
    check("add_wrap_result", 32'(rsp_result), 32'h0);
    check("add_wrap_flags", 32'(rsp_flags), 32'b101);
    check("add_wrap_sreg", 32'(sreg), 32'b101);

    // --- ADD then ADC back-to-back -----------------------------------------
    cycle(1'b1, 4'hA, 'hFFFFF, 'h00002, 1'b1);
    check("chain_add_result", 32'(rsp_result), 32'h1);
    cycle(1'b1, 4'hB, 'h0, 'h0, 1'b1);
    if (CHAIN) begin
      check("chain_adc_result", 32'(rsp_result), 32'h1);
      check("chain_adc_carry", 32'(rsp_flags[2]), 32'd0);
    end else begin
      check("adc_off_err", 32'(rsp_err), 32'd1);
      check("adc_off_sreg", 32'(sreg), 32'b100);
    end

    // --- Back-pressure: response held while consumer stalls ----------------
    cycle(1'b0, 4'h0, 0, 0, 1'b1);
    cycle(1'b1, 4'hA, 'h3, 'h4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'h3, 'h5, 'h6, 1'b0);
      check("hold_result", 32'(rsp_result), 32'h7);
    end
    cycle(1'b1, 4'h3, 'h5, 'h6, 1'b1);
    check("release_result", 32'(rsp_result), 32'h3);

    // --- Shift / rotate / compare corners ----------------------------------
    cycle(1'b1, 4'h5, 'h80001, 0, 1'b1);
    check("shl_result", 32'(rsp_result), 32'h00002);
    check("shl_carry", 32'(rsp_flags[2]), 32'd1);
    cycle(1'b1, 4'h6, 'h00001, 0, 1'b1);
    check("ror_result", 32'(rsp_result), 32'h80000);
    check("ror_flags", 32'(rsp_flags), 32'b110);
    cycle(1'b1, 4'hE, 'h5, 'h5, 1'b1);
    check("cmp_result", 32'(rsp_result), 32'h5);
    check("cmp_flags", 32'(rsp_flags), 32'b001);

    // --- Illegal opcodes leave sreg alone -----------------------------------
    cycle(1'b1, 4'h2, 'h80000, 'h0, 1'b1);
    check("sreg_010", 32'(sreg), 32'b010);
    cycle(1'b1, 4'hF, 'h12345, 'h54321, 1'b1);
    check("ill_err", 32'(rsp_err), 32'd1);
    check("ill_result", 32'(rsp_result), 32'h0);
    check("ill_sreg", 32'(sreg), 32'b010);
    if (!CHAIN) begin
      cycle(1'b1, 4'hB, 'h1, 'h1, 1'b1);
      check("opb_off_err", 32'(rsp_err), 32'd1);
    end

    // --- INC / DEC wrap-around ---------------------------------------------
    cycle(1'b1, 4'h8, 'hFFFFF, 0, 1'b1);
    check("inc_result", 32'(rsp_result), 32'h0);
    check("inc_flags", 32'(rsp_flags), 32'b101);
    cycle(1'b1, 4'h9, 'h0, 0, 1'b1);
    check("dec_result", 32'(rsp_result), 32'hFFFFF);
    check("dec_flags", 32'(rsp_flags), 32'b110);

    // --- Asynchronous reset while a response is held -----------------------
    cycle(1'b1, 4'h2, 'h80001, 'h0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(rsp_valid), 32'd0);
    check("async_rst_sreg", 32'(sreg), 32'd0);
    check("async_rst_ready", 32'(req_ready), 32'd1);
    model_reset();
    req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // --- Randomized traffic with random stalls ------------------------------
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 5) == 0) ? MASK : (longint'($urandom) & MASK);
      b = ($urandom_range(0, 5) == 0) ? MASK : (longint'($urandom) & MASK);
      if ($urandom_range(0, 7) == 0) b = a;
      cycle($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), a, b,
            $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
